// File: rtl/psw_jk_ctrl_pkg.sv
// Shared definitions for the PSW J/K control stage.
//   - Flag bit positions within the NZVC nibble.
//   - Request opcode and FSM state encodings.
//   - jk_encode(): maps a target/mask pair onto J/K commands.
package psw_jk_ctrl_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    OpAlu   = 2'd0,
    OpCcSet = 2'd1,
    OpCcClr = 2'd2,
    OpLoad  = 2'd3
  } req_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StApply = 2'd1,
    StCheck = 2'd2
  } state_e;

  // Returns {J[3:0], K[3:0]}. J and K are never both set for a flag.
  function automatic logic [7:0] jk_encode(input logic [3:0] tgt, input logic [3:0] msk);
    return {tgt & msk, ~tgt & msk};
  endfunction

endpackage

// File: rtl/psw_flag_gen.sv
// NZVC target generation from an ALU result.
// Ports:
//   i_alu_result  ALU result, WIDTH bits
//   i_alu_cout    ALU carry out
//   i_alu_ovf     ALU signed overflow
//   o_flags       {N,Z,V,C} target value
module psw_flag_gen
  import psw_jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_cout,
  input  logic             i_alu_ovf,
  output logic [3:0]       o_flags
);

  always_comb begin
    o_flags         = 4'b0000;
    o_flags[FLAG_N] = i_alu_result[WIDTH-1];
    o_flags[FLAG_Z] = (i_alu_result == '0);
    o_flags[FLAG_V] = i_alu_ovf;
    o_flags[FLAG_C] = i_alu_cout;
  end

endmodule

// File: rtl/psw_jk_ctrl.sv
// PSW J/K control stage. Turns ALU, CC_SET/CC_CLR and LOAD requests into a single
// cycle of registered J/K commands for the N, Z, V and C flip-flops.
// Optional macro PSW_READBACK_CHECK_EN adds a CHECK state that compares psw_in[3:0]
// against the commanded flags one cycle later and sets the sticky chk_err on mismatch.
// Ports:
//   CLK, CLR           clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_op             0 ALU, 1 CC_SET, 2 CC_CLR, 3 LOAD
//   alu_result/cout/ovf ALU outputs used for ALU requests
//   flag_mask          per-flag update enable {N,Z,V,C} (ignored for LOAD)
//   load_data          NZVC value for LOAD
//   psw_in             PSW readback, bits [3:0] used by the check
//   J_*/K_*            registered J/K commands, nonzero only in APPLY
//   done               pulse in the last cycle of a request
//   chk_err            sticky readback-mismatch flag
module psw_jk_ctrl
  import psw_jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  input  logic [3:0]       flag_mask,
  input  logic [3:0]       load_data,
  input  logic [15:0]      psw_in,
  output logic             J_N,
  output logic             K_N,
  output logic             J_Z,
  output logic             K_Z,
  output logic             J_V,
  output logic             K_V,
  output logic             J_C,
  output logic             K_C,
  output logic             done,
  output logic             chk_err
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] w_alu_flags;
  logic [3:0] w_tgt_in;
  logic [3:0] w_msk_in;
  logic       w_accept;
  logic [3:0] r_j;
  logic [3:0] r_k;

  psw_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .i_alu_result (alu_result),
    .i_alu_cout   (alu_cout),
    .i_alu_ovf    (alu_ovf),
    .o_flags      (w_alu_flags)
  );

  assign w_accept = req_valid & req_ready;

  // Target/mask for the request currently presented.
  always_comb begin
    w_tgt_in = 4'b0000;
    w_msk_in = flag_mask;
    case (req_op_e'(req_op))
      OpAlu:   w_tgt_in = w_alu_flags;
      OpCcSet: w_tgt_in = 4'b1111;
      OpCcClr: w_tgt_in = 4'b0000;
      OpLoad: begin
        w_tgt_in = load_data;
        w_msk_in = 4'b1111;
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StApply;
`ifdef PSW_READBACK_CHECK_EN
      StApply: w_state_nxt = StCheck;
`else
      StApply: w_state_nxt = StIdle;
`endif
      StCheck: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (r_state == StIdle);
`ifdef PSW_READBACK_CHECK_EN
    done      = (r_state == StCheck);
`else
    done      = (r_state == StApply);
`endif
  end

  // J/K are loaded on accept and cleared on the following edge, so they are
  // nonzero exactly during APPLY.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_j <= 4'b0000;
      r_k <= 4'b0000;
    end else if (w_accept) begin
      {r_j, r_k} <= jk_encode(w_tgt_in, w_msk_in);
    end else begin
      r_j <= 4'b0000;
      r_k <= 4'b0000;
    end
  end

  assign J_N = r_j[FLAG_N];
  assign K_N = r_k[FLAG_N];
  assign J_Z = r_j[FLAG_Z];
  assign K_Z = r_k[FLAG_Z];
  assign J_V = r_j[FLAG_V];
  assign K_V = r_k[FLAG_V];
  assign J_C = r_j[FLAG_C];
  assign K_C = r_k[FLAG_C];

`ifdef PSW_READBACK_CHECK_EN
  logic [3:0] r_tgt;
  logic [3:0] r_msk;
  logic       r_chk_err;
  logic       w_mismatch;
  logic       w_unused_psw;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_tgt <= 4'b0000;
      r_msk <= 4'b0000;
    end else if (w_accept) begin
      r_tgt <= w_tgt_in;
      r_msk <= w_msk_in;
    end
  end

  assign w_mismatch = |((psw_in[3:0] ^ r_tgt) & r_msk);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_chk_err <= 1'b0;
    end else if ((r_state == StCheck) && w_mismatch) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err      = r_chk_err;
  assign w_unused_psw = ^psw_in[15:4];
`else
  logic w_unused_psw;

  assign chk_err      = 1'b0;
  assign w_unused_psw = ^psw_in;
`endif

endmodule

// File: tb/tb_psw_jk_ctrl.sv
// Directed bench for psw_jk_ctrl. A behavioural NZVC J/K register closes the loop
// on psw_in. Latencies follow PSW_READBACK_CHECK_EN.
module tb_psw_jk_ctrl;

`ifdef PSW_READBACK_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_ovf;
  logic [3:0]  flag_mask;
  logic [3:0]  load_data;
  logic [15:0] psw_in;
  logic        j_n, k_n, j_z, k_z, j_v, k_v, j_c, k_c;
  logic        done;
  logic        chk_err;

  logic [3:0]  psw;
  logic        force_zero;
  logic        exp_err;
  int          n_vec  = 0;
  int          n_fail = 0;

  wire [3:0] j_bus = {j_n, j_z, j_v, j_c};
  wire [3:0] k_bus = {k_n, k_z, k_v, k_c};

  always #5 clk = ~clk;

  psw_jk_ctrl #(
    .WIDTH (16)
  ) dut (
    .CLK        (clk),
    .CLR        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_ovf    (alu_ovf),
    .flag_mask  (flag_mask),
    .load_data  (load_data),
    .psw_in     (psw_in),
    .J_N        (j_n),
    .K_N        (k_n),
    .J_Z        (j_z),
    .K_Z        (k_z),
    .J_V        (j_v),
    .K_V        (k_v),
    .J_C        (j_c),
    .K_C        (k_c),
    .done       (done),
    .chk_err    (chk_err)
  );

  // Behavioural PSW J/K flip-flops
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      psw <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({j_bus[i], k_bus[i]})
          2'b10:   psw[i] <= 1'b1;
          2'b01:   psw[i] <= 1'b0;
          2'b11:   psw[i] <= ~psw[i];
          default: ;
        endcase
      end
    end
  end

  assign psw_in = force_zero ? 16'h0000 : {12'h000, psw};

  // Toggle commands must never appear
  always @(negedge clk) begin
    if (clr && ((j_bus & k_bus) != 4'b0000)) begin
      n_fail++;
      $display("FAIL jk_toggle: J=%b K=%b required no bit set in both", j_bus, k_bus);
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic [3:0]  mask;
    logic [3:0]  ld;
    logic [3:0]  j;
    logic [3:0]  k;
    logic [3:0]  psw;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_op     = v.op;
    alu_result = v.res;
    alu_cout   = v.cout;
    alu_ovf    = v.ovf;
    flag_mask  = v.mask;
    load_data  = v.ld;
  endtask

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({nm, "/ready_wait"}, {15'd0, req_ready}, 16'd1);
  endtask

  // One full request: accept, APPLY, optional CHECK, back to IDLE.
  task automatic do_req(input vec_t v, input string nm);
    wait_ready(nm);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({nm, "/J"}, {12'd0, j_bus}, {12'd0, v.j});
    chk({nm, "/K"}, {12'd0, k_bus}, {12'd0, v.k});
    chk({nm, "/ready_apply"}, {15'd0, req_ready}, 16'd0);
    chk({nm, "/done_apply"}, {15'd0, done}, {15'd0, ~CheckEn});
    @(posedge clk);
    #1;
    chk({nm, "/psw"}, {12'd0, psw}, {12'd0, v.psw});
    if (CheckEn) begin
      chk({nm, "/done_check"}, {15'd0, done}, 16'd1);
      chk({nm, "/ready_check"}, {15'd0, req_ready}, 16'd0);
      @(posedge clk);
      #1;
    end
    chk({nm, "/ready_end"}, {15'd0, req_ready}, 16'd1);
    chk({nm, "/done_end"}, {15'd0, done}, 16'd0);
    chk({nm, "/chk_err"}, {15'd0, chk_err}, {15'd0, exp_err});
  endtask

  initial begin
    int   n;
    logic seen;
    vec_t v;

    //          op     res       co    ov    mask     ld       J        K        psw
    tbl[0]  = '{2'd0, 16'h8000, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1001, 4'b0110, 4'b1001};
    tbl[1]  = '{2'd0, 16'h0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b1101};
    tbl[2]  = '{2'd3, 16'h0000, 1'b0, 1'b0, 4'b0000, 4'b0110, 4'b0110, 4'b1001, 4'b0110};
    tbl[3]  = '{2'd1, 16'h0000, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0111};
    tbl[4]  = '{2'd2, 16'h0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0110};
    tbl[5]  = '{2'd0, 16'h0001, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b1101, 4'b0010};
    tbl[6]  = '{2'd0, 16'hFFFF, 1'b1, 1'b0, 4'b1010, 4'b0000, 4'b1000, 4'b0010, 4'b1000};
    tbl[7]  = '{2'd0, 16'h0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0111, 4'b1000, 4'b0111};
    tbl[8]  = '{2'd3, 16'h0000, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b1010, 4'b0101, 4'b1010};
    tbl[9]  = '{2'd2, 16'h0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[10] = '{2'd0, 16'h0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};

    clr        = 1'b0;
    req_valid  = 1'b0;
    force_zero = 1'b0;
    exp_err    = 1'b0;
    drive(tbl[0]);
    #3;
    chk("rst/ready", {15'd0, req_ready}, 16'd1);
    chk("rst/jk", {8'd0, j_bus, k_bus}, 16'd0);
    chk("rst/done", {15'd0, done}, 16'd0);
    chk("rst/chk_err", {15'd0, chk_err}, 16'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i], $sformatf("vec%0d", i));
    end

    // Back-to-back CC_SET then CC_CLR with req_valid held high
    v = '{2'd1, 16'h0000, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0, 4'b0, 4'b0};
    wait_ready("b2b");
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    v = '{2'd2, 16'h0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0, 4'b0, 4'b0};
    drive(v);
    n = 1;
    while (!req_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b/accept_spacing", n[15:0], CheckEn ? 16'd3 : 16'd2);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b/K_second", {12'd0, k_bus}, 16'h0001);
    wait_ready("b2b_end");
    chk("b2b/psw", {12'd0, psw}, 16'h0002);

    // Readback forced to zero after LOAD 1111
    force_zero = 1'b1;
    exp_err    = CheckEn;
    do_req('{2'd3, 16'h0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111},
           "force");
    force_zero = 1'b0;
    do_req('{2'd2, 16'h0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000},
           "sticky");

    // Reset in APPLY
    wait_ready("rstapply");
    drive('{2'd1, 16'h0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0, 4'b0, 4'b0});
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rstapply/J_before", {12'd0, j_bus}, 16'h000F);
    #2;
    clr = 1'b0;
    #1;
    chk("rstapply/jk", {8'd0, j_bus, k_bus}, 16'd0);
    chk("rstapply/ready", {15'd0, req_ready}, 16'd1);
    chk("rstapply/done", {15'd0, done}, 16'd0);
    chk("rstapply/chk_err", {15'd0, chk_err}, 16'd0);
    @(negedge clk);
    clr  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (done || (j_bus != 4'b0000) || (k_bus != 4'b0000)) seen = 1'b1;
    end
    chk("rstapply/no_pulse_after", {15'd0, seen}, 16'd0);
    chk("rstapply/ready_after", {15'd0, req_ready}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
